dispatch_unit: RTL

- Parametrised successor to the single-slot decode/issue stage of the Tomasulo core.
- Buffers decoded instructions in an IQ_DEPTH FIFO and keeps an internal rename (register-to-tag) table.
- Allocates ROB tags via a handshake, resolves operands from the register file plus the CDB bypass, and issues one registered bundle per cycle to the selected reservation station.
- Sits between decoder and reservation stations; replaces the combinational tag/value MUX and the negedge tag toggle with a fully synchronous path.

---
 rtl/dispatch_unit_pkg.sv | 31 +++
 rtl/dispatch_unit_rename_table.sv | 51 +++++
 rtl/dispatch_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_unit_pkg.sv
// Shared definitions for the dispatch stage: invalid tag, unit encodings and
// the decoded bundle as produced by the decoder at default widths.
package dispatch_unit_pkg;

   localparam int unsigned TAG_INVALID = 0;

   localparam int unsigned DEF_XLEN   = 32;
   localparam int unsigned DEF_NREG_W = 5;
   localparam int unsigned DEF_OP_W   = 6;

   typedef enum logic [2:0] {
      EXU_ALU = 3'd0,
      EXU_MUL = 3'd1,
      EXU_LSU = 3'd2,
      EXU_BR  = 3'd3,
      EXU_ERR = 3'd4
   } exu_e;

   typedef struct packed {
      logic [DEF_OP_W-1:0]   op;
      exu_e                  ex_unit;
      logic [DEF_NREG_W-1:0] rs1;
      logic [DEF_NREG_W-1:0] rs2;
      logic [DEF_NREG_W-1:0] rd;
      logic [1:0]            rs_en;
      logic                  rd_en;
      logic [DEF_XLEN-1:0]   imm;
      logic                  imm_en;
   } dec_bundle_t;

endpackage

// File: rtl/dispatch_unit_rename_table.sv
// Register-to-ROB-tag map: two read ports, one dispatch write port,
// commit-clear on tag match and whole-table flush clear.
module rename_table
   import dispatch_unit_pkg::*;
#(
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned NREG_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [NREG_W-1:0] raddr1_i,
   input  logic [NREG_W-1:0] raddr2_i,
   output logic [TAG_W-1:0]  rtag1_o,
   output logic [TAG_W-1:0]  rtag2_o,
   input  logic              we_i,
   input  logic [NREG_W-1:0] waddr_i,
   input  logic [TAG_W-1:0]  wtag_i,
   input  logic              commit_valid_i,
   input  logic [NREG_W-1:0] commit_rd_i,
   input  logic [TAG_W-1:0]  commit_tag_i
);

   localparam int unsigned NREG = 1 << NREG_W;

   logic [TAG_W-1:0] tab_q [NREG];
   logic [TAG_W-1:0] tab_d [NREG];

   assign rtag1_o = tab_q[raddr1_i];
   assign rtag2_o = tab_q[raddr2_i];

   // Write is applied after the commit clear so a same-cycle rename wins.
   always_comb begin
      tab_d = tab_q;
      if (commit_valid_i && tab_q[commit_rd_i] == commit_tag_i)
         tab_d[commit_rd_i] = TAG_W'(TAG_INVALID);
      if (we_i)
         tab_d[waddr_i] = wtag_i;
      if (flush)
         for (int unsigned i = 0; i < NREG; i++) tab_d[i] = TAG_W'(TAG_INVALID);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) tab_q[i] <= TAG_W'(TAG_INVALID);
      end else begin
         tab_q <= tab_d;
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// Decode-to-issue stage: instruction FIFO, rename lookup with CDB bypass,
// ROB tag allocation and one registered issue bundle per cycle.
module dispatch_unit
   import dispatch_unit_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned NREG_W   = 5,
   parameter int unsigned OP_W     = 6,
   parameter int unsigned EXU_N    = 4,
   parameter int unsigned IQ_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [OP_W-1:0]              in_op,
   input  logic [$clog2(EXU_N+1)-1:0]   in_ex_unit,
   input  logic [NREG_W-1:0]            in_rs1,
   input  logic [NREG_W-1:0]            in_rs2,
   input  logic [NREG_W-1:0]            in_rd,
   input  logic [1:0]                   in_rs_en,
   input  logic                         in_rd_en,
   input  logic [XLEN-1:0]              in_imm,
   input  logic                         in_imm_en,
   output logic [NREG_W-1:0]            rf_raddr1,
   output logic [NREG_W-1:0]            rf_raddr2,
   input  logic [XLEN-1:0]              rf_rdata1,
   input  logic [XLEN-1:0]              rf_rdata2,
   input  logic                         rob_avail,
   input  logic [TAG_W-1:0]             rob_tag,
   output logic                         rob_alloc,
   output logic [NREG_W-1:0]            rob_rd,
   output logic [OP_W-1:0]              rob_op,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [XLEN-1:0]              cdb_val,
   input  logic                         commit_valid,
   input  logic [NREG_W-1:0]            commit_rd,
   input  logic [TAG_W-1:0]             commit_tag,
   input  logic [EXU_N-1:0]             rs_full,
   output logic                         out_valid,
   output logic [$clog2(EXU_N+1)-1:0]   out_ex_unit,
   output logic [OP_W-1:0]              out_op,
   output logic [TAG_W-1:0]             out_tag1,
   output logic [TAG_W-1:0]             out_tag2,
   output logic [XLEN-1:0]              out_val1,
   output logic [XLEN-1:0]              out_val2,
   output logic [TAG_W-1:0]             out_target,
   output logic                         illegal
);

   localparam int unsigned EXU_W = $clog2(EXU_N + 1);
   localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [EXU_W-1:0]  ex_unit;
      logic [NREG_W-1:0] rs1;
      logic [NREG_W-1:0] rs2;
      logic [NREG_W-1:0] rd;
      logic [1:0]        rs_en;
      logic              rd_en;
      logic [XLEN-1:0]   imm;
      logic              imm_en;
   } bundle_t;

   bundle_t           iq_q [IQ_DEPTH];
   bundle_t           head;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              head_valid, head_illegal, unit_full;
   logic              fire, drop, pop, push;
   logic [TAG_W-1:0]  ren1, ren2, src1_tag, src2_tag;
   logic [XLEN-1:0]   src1_val, src2_val;

   logic              out_valid_q, out_valid_d, illegal_q, illegal_d;
   logic [EXU_W-1:0]  out_ex_unit_q, out_ex_unit_d;
   logic [OP_W-1:0]   out_op_q, out_op_d;
   logic [TAG_W-1:0]  out_tag1_q, out_tag1_d, out_tag2_q, out_tag2_d;
   logic [TAG_W-1:0]  out_target_q, out_target_d;
   logic [XLEN-1:0]   out_val1_q, out_val1_d, out_val2_q, out_val2_d;

   assign head         = iq_q[rd_ptr_q];
   assign head_valid   = (cnt_q != '0);
   assign head_illegal = (head.ex_unit >= EXU_W'(EXU_N));
   assign in_ready     = (cnt_q != CNT_W'(IQ_DEPTH));

   always_comb begin
      unit_full = 1'b0;
      for (int unsigned i = 0; i < EXU_N; i++)
         if (head.ex_unit == EXU_W'(i)) unit_full = rs_full[i];
   end

   assign fire = head_valid && !flush && !head_illegal && rob_avail && !unit_full;
   assign drop = head_valid && !flush && head_illegal;
   assign pop  = fire || drop;
   assign push = in_valid && in_ready && !flush;

   assign rf_raddr1 = head.rs1;
   assign rf_raddr2 = head.rs2;
   assign rob_alloc = fire;
   assign rob_rd    = head.rd_en ? head.rd : '0;
   assign rob_op    = head.op;

   rename_table #(
      .TAG_W  (TAG_W),
      .NREG_W (NREG_W)
   ) u_rename (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .raddr1_i       (head.rs1),
      .raddr2_i       (head.rs2),
      .rtag1_o        (ren1),
      .rtag2_o        (ren2),
      .we_i           (fire && head.rd_en && head.rd != '0),
      .waddr_i        (head.rd),
      .wtag_i         (rob_tag),
      .commit_valid_i (commit_valid),
      .commit_rd_i    (commit_rd),
      .commit_tag_i   (commit_tag)
   );

   // A pending producer is either still outstanding (tag) or broadcasting now (value).
   always_comb begin
      src1_tag = TAG_W'(TAG_INVALID);
      src1_val = rf_rdata1;
      if (head.rs_en[0] && head.rs1 != '0 && ren1 != TAG_W'(TAG_INVALID)) begin
         if (cdb_valid && cdb_tag == ren1) src1_val = cdb_val;
         else                              src1_tag = ren1;
      end
      src2_tag = TAG_W'(TAG_INVALID);
      src2_val = rf_rdata2;
      if (head.imm_en) begin
         src2_val = head.imm;
      end else if (head.rs_en[1] && head.rs2 != '0 && ren2 != TAG_W'(TAG_INVALID)) begin
         if (cdb_valid && cdb_tag == ren2) src2_val = cdb_val;
         else                              src2_tag = ren2;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (push && !pop)      cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         iq_q[wr_ptr_q] <= '{op: in_op, ex_unit: in_ex_unit, rs1: in_rs1, rs2: in_rs2,
                             rd: in_rd, rs_en: in_rs_en, rd_en: in_rd_en,
                             imm: in_imm, imm_en: in_imm_en};
      end
   end

   always_comb begin
      out_valid_d   = fire;
      illegal_d     = drop;
      out_ex_unit_d = out_ex_unit_q;
      out_op_d      = out_op_q;
      out_tag1_d    = out_tag1_q;
      out_tag2_d    = out_tag2_q;
      out_val1_d    = out_val1_q;
      out_val2_d    = out_val2_q;
      out_target_d  = out_target_q;
      if (fire) begin
         out_ex_unit_d = head.ex_unit;
         out_op_d      = head.op;
         out_tag1_d    = src1_tag;
         out_tag2_d    = src2_tag;
         out_val1_d    = src1_val;
         out_val2_d    = src2_val;
         out_target_d  = rob_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         cnt_q         <= '0;
         out_valid_q   <= 1'b0;
         illegal_q     <= 1'b0;
         out_ex_unit_q <= '0;
         out_op_q      <= '0;
         out_tag1_q    <= '0;
         out_tag2_q    <= '0;
         out_val1_q    <= '0;
         out_val2_q    <= '0;
         out_target_q  <= '0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         cnt_q         <= cnt_d;
         out_valid_q   <= out_valid_d;
         illegal_q     <= illegal_d;
         out_ex_unit_q <= out_ex_unit_d;
         out_op_q      <= out_op_d;
         out_tag1_q    <= out_tag1_d;
         out_tag2_q    <= out_tag2_d;
         out_val1_q    <= out_val1_d;
         out_val2_q    <= out_val2_d;
         out_target_q  <= out_target_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign illegal     = illegal_q;
   assign out_ex_unit = out_ex_unit_q;
   assign out_op      = out_op_q;
   assign out_tag1    = out_tag1_q;
   assign out_tag2    = out_tag2_q;
   assign out_val1    = out_val1_q;
   assign out_val2    = out_val2_q;
   assign out_target  = out_target_q;

endmodule
